uart_tx_sched: RTL and testbench

//  Round-robin scheduler that shares one uart_send transmitter between N_REQ byte producers.
//  - Issues one-cycle valid/data pulses to the transmitter.
//  - uart_send has no busy output, so this block paces pulses with a frame timer.
//  - Acknowledges each requester when its byte is taken.
//  - Sits between application logic (keyboard/LED/echo sources) and uart_send.

---
 rtl/uart_tx_sched_if.sv | 20 ++
 rtl/uart_tx_sched.sv | 129 ++++++++++++
 tb/tb_uart_tx_sched.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester/transmitter signal bundle for uart_tx_sched (UART_SCHED_LOCK_EN adds req_last)
interface uart_tx_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ack;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               busy;
`ifdef UART_SCHED_LOCK_EN
  logic [N_REQ-1:0]   req_last;

  modport master (output req, req_data, req_last, input req_ack, tx_valid, tx_data, busy);
  modport slave  (input req, req_data, req_last, output req_ack, tx_valid, tx_data, busy);
`else
  modport master (output req, req_data, input req_ack, tx_valid, tx_data, busy);
  modport slave  (input req, req_data, output req_ack, tx_valid, tx_data, busy);
`endif
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte scheduler pacing one uart_send transmitter (UART_SCHED_LOCK_EN enables message lock)
module uart_tx_sched #(
  parameter int N_REQ      = 4,
  parameter int BIT_CYCLES = 10417,
  parameter int GAP_CYCLES = 4
) (
  input logic            clk,
  input logic            rst,
  uart_tx_sched_if.slave bus
);
  localparam int FRAME_CYCLES = 10 * BIT_CYCLES + GAP_CYCLES;
  localparam int TW = $clog2(FRAME_CYCLES + 1);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] grant_q;
  logic [TW-1:0] timer_q;
  logic [PW-1:0] search_base;
  logic [PW-1:0] rr_grant;
  logic          rr_hit;
  logic [PW-1:0] sel_grant;
  logic          sel_hit;

  function automatic logic [PW-1:0] wrap_idx(input int v);
    return PW'(v % N_REQ);
  endfunction

`ifdef UART_SCHED_LOCK_EN
  logic lock_q;
  logic last_q;
  logic lock_drop;

  // A locked owner that has withdrawn its request releases the lock; the search then restarts after it.
  assign lock_drop   = lock_q && !bus.req[grant_q];
  assign search_base = lock_drop ? wrap_idx(int'(grant_q) + 1) : rr_ptr_q;
  assign sel_hit     = (lock_q && !lock_drop) ? 1'b1 : rr_hit;
  assign sel_grant   = (lock_q && !lock_drop) ? grant_q : rr_grant;
`else
  assign search_base = rr_ptr_q;
  assign sel_hit     = rr_hit;
  assign sel_grant   = rr_grant;
`endif

  // First pending request at or after the search base, wrapping modulo N_REQ.
  always_comb begin
    rr_hit   = 1'b0;
    rr_grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!rr_hit && bus.req[wrap_idx(int'(search_base) + i)]) begin
        rr_hit   = 1'b1;
        rr_grant = wrap_idx(int'(search_base) + i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: one issue cycle, then hold off until the frame timer expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_hit) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (timer_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, grant bookkeeping and frame timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.req_ack  <= '0;
      bus.busy     <= 1'b0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      timer_q      <= '0;
`ifdef UART_SCHED_LOCK_EN
      lock_q       <= 1'b0;
      last_q       <= 1'b0;
`endif
    end else begin
      bus.tx_valid <= 1'b0;
      bus.req_ack  <= '0;
      bus.busy     <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
`ifdef UART_SCHED_LOCK_EN
          if (lock_drop) begin
            lock_q   <= 1'b0;
            rr_ptr_q <= wrap_idx(int'(grant_q) + 1);
          end
`endif
          if (sel_hit) begin
            grant_q      <= sel_grant;
            bus.tx_data  <= bus.req_data[8*sel_grant +: 8];
            bus.tx_valid <= 1'b1;
            bus.req_ack  <= N_REQ'(1) << sel_grant;
`ifdef UART_SCHED_LOCK_EN
            last_q       <= bus.req_last[sel_grant];
`endif
          end
        end
        ISSUE: begin
          timer_q <= TIMER_LOAD;
`ifdef UART_SCHED_LOCK_EN
          lock_q <= !last_q;
          if (last_q) rr_ptr_q <= wrap_idx(int'(grant_q) + 1);
`else
          rr_ptr_q <= wrap_idx(int'(grant_q) + 1);
`endif
        end
        WAIT: begin
          if (timer_q != '0) timer_q <= timer_q - TW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with serial loopback
module tb_uart_tx_sched;
  localparam int N     = 4;
  localparam int BIT   = 4;
  localparam int GAP   = 2;
  localparam int FRAME = 10 * BIT + GAP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.N_REQ(N)) bus ();

  uart_tx_sched #(.N_REQ(N), .BIT_CYCLES(BIT), .GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int         exp_g[$];
  logic [7:0] exp_d[$];
  logic [7:0] rx_exp[$];
  int         drv_g[$];

  logic [N-1:0] cur_req = '0;
  logic [N-1:0] cur_last = '1;
  logic [7:0]   cur_data[N];
  int           ptr = 0;
  bit           lock_on = 1'b0;
  int           lock_g = 0;

  bit space_on = 1'b0;
  int last_valid = -1;
  int cyc = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply();
    bus.req = cur_req;
    for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = cur_data[i];
`ifdef UART_SCHED_LOCK_EN
    bus.req_last = cur_last;
`endif
  endtask

  // Reference arbitration: next grant from the pointer (or lock owner), queued as expected output.
  task automatic predict();
    int g;
    g = -1;
`ifdef UART_SCHED_LOCK_EN
    if (lock_on && !cur_req[lock_g]) begin
      lock_on = 1'b0;
      ptr = (lock_g + 1) % N;
    end
    if (lock_on) g = lock_g;
    else
`endif
    for (int k = 0; k < N; k++)
      if (g < 0 && cur_req[(ptr + k) % N]) g = (ptr + k) % N;
    if (g >= 0) begin
      exp_g.push_back(g);
      exp_d.push_back(cur_data[g]);
      rx_exp.push_back(cur_data[g]);
      drv_g.push_back(g);
`ifdef UART_SCHED_LOCK_EN
      if (!cur_last[g]) begin
        lock_on = 1'b1;
        lock_g = g;
      end else begin
        lock_on = 1'b0;
        ptr = (g + 1) % N;
      end
`else
      ptr = (g + 1) % N;
`endif
    end
  endtask

  task automatic take_ack(output int g, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ack == '0 && n < 300);
    if (bus.req_ack == '0) check_eq("ack_timeout", n, 0);
    g = (drv_g.size() != 0) ? drv_g.pop_front() : -1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check_eq("idle_timeout", n, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr = 0;
    lock_on = 1'b0;
    drv_g.delete();
  endtask

  // Scoreboard monitor: every issued byte must match the model's next grant and be spaced by a full frame.
  always @(negedge clk) begin
    int g;
    logic [7:0] d;
    cyc++;
    if (!rst && bus.tx_valid) begin
      if (exp_g.size() == 0) begin
        check_eq("unexpected_tx_valid", 1, 0);
      end else begin
        g = exp_g.pop_front();
        d = exp_d.pop_front();
        check_eq("tx_data", bus.tx_data, d);
        check_eq("req_ack", bus.req_ack, 1 << g);
      end
      if (space_on && last_valid >= 0) check_eq("tx_spacing", cyc - last_valid, FRAME + 2);
      last_valid = cyc;
    end else if (!rst && bus.req_ack != '0) begin
      check_eq("ack_without_valid", bus.req_ack, 0);
    end
  end

  // Behavioural uart_send: 8N1 frame started by a valid pulse, no busy output.
  logic       line = 1'b1;
  logic       tx_act = 1'b0;
  logic [9:0] tx_sh = '1;
  int         tx_cnt = 0;
  int         tx_bit = 0;
  int         overlap = 0;
  always @(posedge clk) begin
    if (rst) begin
      tx_act <= 1'b0;
      line   <= 1'b1;
    end else if (bus.tx_valid) begin
      if (tx_act) overlap <= overlap + 1;
      tx_act <= 1'b1;
      tx_sh  <= {1'b1, bus.tx_data, 1'b0};
      tx_cnt <= 0;
      tx_bit <= 0;
      line   <= 1'b0;
    end else if (tx_act) begin
      if (tx_cnt == BIT - 1) begin
        tx_cnt <= 0;
        if (tx_bit == 9) begin
          tx_act <= 1'b0;
          line   <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 1;
          line   <= tx_sh[tx_bit + 1];
        end
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end
  end

  // Serial receiver sampling mid-bit; decoded bytes are compared with the model's byte order.
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  int         rx_frames = 0;
  logic [7:0] rx_byte = '0;
  always @(negedge clk) begin
    int k;
    if (rst) begin
      rx_on = 1'b0;
      rx_exp.delete();
    end else if (!rx_on) begin
      if (!line) begin
        rx_on = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % BIT == BIT / 2) begin
        k = rx_cnt / BIT;
        if (k >= 1 && k <= 8) rx_byte[k-1] = line;
        if (k == 9) begin
          rx_on = 1'b0;
          rx_frames++;
          check_eq("rx_stop_bit", line, 1);
          if (rx_exp.size() == 0) check_eq("rx_unexpected_byte", rx_byte, -1);
          else check_eq("rx_byte", rx_byte, rx_exp.pop_front());
        end
      end
    end
  end

  initial begin
    int g, n, nb;
    logic [N-1:0] nw;

    for (int i = 0; i < N; i++) cur_data[i] = '0;
    apply();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_tx_valid", bus.tx_valid, 0);
    check_eq("rst_tx_data", bus.tx_data, 0);
    check_eq("rst_req_ack", bus.req_ack, 0);

    // Single request: one-cycle latency and 43 busy cycles.
    cur_req = 4'b0001;
    cur_data[0] = 8'h55;
    apply();
    predict();
    take_ack(g, n);
    check_eq("issue_latency", n, 1);
    cur_req = '0;
    apply();
    nb = 0;
    while (bus.busy && nb < 200) begin
      nb++;
      @(negedge clk);
    end
    check_eq("busy_length", nb, FRAME + 1);

    // All requesting, fresh byte after each ack: order 0,1,2,3,0 at full-frame spacing.
    do_reset();
    last_valid = -1;
    space_on = 1'b1;
    cur_req = 4'b1111;
    for (int i = 0; i < N; i++) cur_data[i] = 8'($urandom);
    apply();
    predict();
    for (int t = 0; t < 5; t++) begin
      take_ack(g, n);
      if (t == 4) cur_req = '0;
      else if (g >= 0) cur_data[g] = 8'($urandom);
      apply();
      if (t != 4) predict();
    end
    wait_idle();
    space_on = 1'b0;

    // Pointer wrap: grant 1 leaves pointer at 2, then 0011 grants 0 and then 1.
    cur_req = 4'b0010;
    cur_data[1] = 8'h11;
    apply();
    predict();
    take_ack(g, n);
    cur_req = '0;
    apply();
    wait_idle();
    cur_req = 4'b0011;
    cur_data[0] = 8'h20;
    cur_data[1] = 8'h21;
    apply();
    predict();
    take_ack(g, n);
    cur_data[0] = 8'h30;
    apply();
    predict();
    take_ack(g, n);
    cur_req = '0;
    apply();
    wait_idle();

    // Reset ten cycles into WAIT aborts the frame and clears the pointer.
    cur_req = 4'b0100;
    cur_data[2] = 8'h44;
    apply();
    predict();
    take_ack(g, n);
    cur_req = '0;
    apply();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_tx_valid", bus.tx_valid, 0);
    check_eq("abort_tx_data", bus.tx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    ptr = 0;
    lock_on = 1'b0;
    drv_g.delete();
    cur_req = 4'b1010;
    cur_data[1] = 8'h61;
    cur_data[3] = 8'h63;
    apply();
    predict();
    take_ack(g, n);
    cur_req = '0;
    apply();
    wait_idle();
    cur_req = 4'b1000;
    cur_data[3] = 8'h73;
    apply();
    predict();
    take_ack(g, n);
    cur_req = '0;
    apply();
    wait_idle();

    // Loopback bytes A5 then 3C from one requester, back to back.
    last_valid = -1;
    space_on = 1'b1;
    cur_req = 4'b0001;
    cur_data[0] = 8'hA5;
    apply();
    predict();
    take_ack(g, n);
    cur_data[0] = 8'h3C;
    apply();
    predict();
    take_ack(g, n);
    cur_req = '0;
    apply();
    wait_idle();
    space_on = 1'b0;

`ifdef UART_SCHED_LOCK_EN
    // Message lock: non-last byte holds the grant, last byte or withdrawal releases it.
    do_reset();
    cur_req = 4'b0011;
    cur_last = 4'b1110;
    cur_data[0] = 8'h80;
    cur_data[1] = 8'h90;
    apply();
    predict();
    take_ack(g, n);
    cur_data[0] = 8'h81;
    cur_last[0] = 1'b1;
    apply();
    predict();
    take_ack(g, n);
    cur_req[0] = 1'b0;
    apply();
    predict();
    take_ack(g, n);
    cur_req = '0;
    apply();
    wait_idle();
    cur_req = 4'b0011;
    cur_last = 4'b1110;
    cur_data[0] = 8'h82;
    cur_data[1] = 8'h91;
    apply();
    predict();
    take_ack(g, n);
    cur_req[0] = 1'b0;
    apply();
    predict();
    take_ack(g, n);
    cur_req = '0;
    cur_last = '1;
    apply();
    wait_idle();
`endif

    // Randomized traffic with requests kept pending so every pulse is a full frame apart.
    last_valid = -1;
    space_on = 1'b1;
    cur_req = N'($urandom_range(1, (1 << N) - 1));
    for (int i = 0; i < N; i++) cur_data[i] = 8'($urandom);
    apply();
    predict();
    for (int t = 0; t < 20; t++) begin
      take_ack(g, n);
      if (g >= 0) begin
        if ($urandom_range(0, 1) == 1) cur_data[g] = 8'($urandom);
        else cur_req[g] = 1'b0;
      end
      nw = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (nw[i] && !cur_req[i]) begin
          cur_req[i] = 1'b1;
          cur_data[i] = 8'($urandom);
        end
      if (cur_req == '0) begin
        g = $urandom_range(0, N - 1);
        cur_req[g] = 1'b1;
        cur_data[g] = 8'($urandom);
      end
      if (t == 19) cur_req = '0;
      apply();
      if (t != 19) predict();
    end
    wait_idle();
    space_on = 1'b0;
    repeat (FRAME + 10) @(negedge clk);

    check_eq("scoreboard_drained", exp_g.size(), 0);
    check_eq("rx_drained", rx_exp.size(), 0);
    check_eq("frame_overlap", overlap, 0);
    check_eq("rx_frames_seen", (rx_frames >= 30) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
